udp_tx_sched: RTL and testbench

Round-robin scheduler that shares the single UDP transmit channel of the `mac` block among up to four frame sources, such as the FIFO-to-MAC senders. It selects one requester and presents that requester's payload length to the MAC. It drives the `fs_udp_tx`/`fd_udp_tx` start/done handshake, then enforces a minimum idle gap before the next grant. The block sits in the `gmii_txc` domain between the requesters and `mac`. `sel` steers the external `udp_txd`/`udp_txen` mux.

---
 rtl/udp_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_udp_tx_sched.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_sched.sv
// Round-robin scheduler that shares the MAC UDP transmit channel among NREQ frame sources.
// Optional UPTX watchdog abort is enabled by defining UDP_TX_SCHED_TIMEOUT_EN.
module udp_tx_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned GAP     = 8,
  parameter logic [11:0] LEN_MAX = 12'd1472,
  parameter logic [15:0] TIMEOUT = 16'd65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [12*NREQ-1:0]   req_len,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic                 fs_udp_tx,
  input  logic                 fd_udp_tx,
  output logic [11:0]          udp_tx_len,
  output logic [1:0]           sel,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StUptx = 2'd1;
  localparam logic [1:0] StLast = 2'd2;
  localparam logic [1:0] StGap  = 2'd3;

  logic [1:0] state_q;
  logic [1:0] ptr_q;
  logic [7:0] gap_cnt_q;

  logic [3:0]  req_pad;
  logic [47:0] len_pad;
  logic [2:0]  idx;
  logic [1:0]  win;
  logic        win_vld;
  logic [11:0] win_len;
  logic        len_ok;
  logic [1:0]  ptr_nxt;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v[NREQ-1:0];
  endfunction

  // Pad to four lanes so the search and length mux are independent of NREQ.
  always_comb begin
    req_pad = '0;
    req_pad[NREQ-1:0] = req;
    len_pad = '0;
    len_pad[12*NREQ-1:0] = req_len;
  end

  // First set request searching ptr, ptr+1, ... modulo NREQ.
  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = {1'b0, ptr_q} + i[2:0];
      if (idx >= NREQ[2:0]) idx = idx - NREQ[2:0];
      if (!win_vld && req_pad[idx[1:0]]) begin
        win_vld = 1'b1;
        win     = idx[1:0];
      end
    end
  end

  always_comb begin
    win_len = len_pad[11:0];
    unique case (win)
      2'd0: win_len = len_pad[11:0];
      2'd1: win_len = len_pad[23:12];
      2'd2: win_len = len_pad[35:24];
      2'd3: win_len = len_pad[47:36];
      default: win_len = len_pad[11:0];
    endcase
  end

  assign len_ok  = (win_len != 12'd0) && (win_len <= LEN_MAX);
  assign ptr_nxt = (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
  assign busy    = (state_q != StIdle);

`ifdef UDP_TX_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gap_cnt_q  <= '0;
      grant      <= '0;
      done       <= '0;
      err        <= '0;
      fs_udp_tx  <= 1'b0;
      udp_tx_len <= '0;
      sel        <= '0;
      frame_cnt  <= '0;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      done <= '0;
      err  <= '0;
      case (state_q)
        StIdle: begin
          if (win_vld) begin
            ptr_q <= ptr_nxt;
            if (len_ok) begin
              grant      <= onehot(win);
              sel        <= win;
              udp_tx_len <= win_len;
              fs_udp_tx  <= 1'b1;
              state_q    <= StUptx;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
              to_cnt_q   <= '0;
`endif
            end else begin
              // Rejected requester; arbitration continues next cycle.
              err <= onehot(win);
            end
          end
        end
        StUptx: begin
          if (fd_udp_tx) begin
            fs_udp_tx <= 1'b0;
            state_q   <= StLast;
          end
`ifdef UDP_TX_SCHED_TIMEOUT_EN
          else if (to_cnt_q == TIMEOUT - 16'd1) begin
            fs_udp_tx <= 1'b0;
            grant     <= '0;
            err       <= onehot(sel);
            gap_cnt_q <= 8'(GAP - 1);
            state_q   <= StGap;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
`endif
        end
        StLast: begin
          done      <= onehot(sel);
          grant     <= '0;
          frame_cnt <= frame_cnt + 16'd1;
          gap_cnt_q <= 8'(GAP - 1);
          state_q   <= StGap;
        end
        StGap: begin
          if (gap_cnt_q == 8'd0) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_sched.sv
// Scoreboard bench for udp_tx_sched: a rotating-priority model predicts grant/done/err events.
module tb_udp_tx_sched;

  localparam int NREQ    = 4;
  localparam int GAP     = 8;
  localparam int LEN_MAX = 1472;
  localparam int EvGrant = 0;
  localparam int EvDone  = 1;
  localparam int EvErr   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [47:0] req_len;
  logic [3:0]  grant, done, err;
  logic        fs_udp_tx, fd_udp_tx;
  logic [11:0] udp_tx_len;
  logic [1:0]  sel;
  logic        busy;
  logic [15:0] frame_cnt;

  logic fd_auto, fd_force, mac_auto, fs_prev;
  assign fd_udp_tx = fd_auto | fd_force;

  always #5 clk = ~clk;

  udp_tx_sched #(
    .NREQ(NREQ), .GAP(GAP), .LEN_MAX(12'd1472), .TIMEOUT(16'd100)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .grant(grant), .done(done),
    .err(err), .fs_udp_tx(fs_udp_tx), .fd_udp_tx(fd_udp_tx), .udp_tx_len(udp_tx_len),
    .sel(sel), .busy(busy), .frame_cnt(frame_cnt)
  );

  typedef struct {
    int kind;
    int idx;
    int len;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  mptr  = 0;  // model rotation pointer
  int  mcnt  = 0;  // model completed-frame count

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int idx, input int len, input int cnt);
    ev_t e;
    e.kind = kind; e.idx = idx; e.len = len; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // All requesters in mask raised together while idle: served strictly in rotating order.
  task automatic predict(input logic [3:0] mask, input int lens[4]);
    logic [3:0] rem;
    int w;
    rem = mask;
    while (rem != 4'd0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && rem[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
      rem[w] = 1'b0;
      mptr = (w + 1) % NREQ;
      if (lens[w] >= 1 && lens[w] <= LEN_MAX) begin
        mcnt = (mcnt + 1) % 65536;
        push(EvGrant, w, lens[w], 0);
        push(EvDone, w, 0, mcnt);
      end else begin
        push(EvErr, w, 0, 0);
      end
    end
  endtask

  task automatic observe(input int kind, input logic [3:0] vec);
    ev_t e;
    int idx;
    idx = 0;
    for (int i = 0; i < NREQ; i++) if (vec[i]) idx = i;
    check("ev_onehot", $countones(vec), 1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: kind %0d idx %0d seen, none expected (t=%0t)",
               kind, idx, $time);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", kind, e.kind);
    check("ev_idx", idx, e.idx);
    if (kind == EvGrant) begin
      check("ev_len", udp_tx_len, e.len);
      check("ev_sel", sel, e.idx);
    end
    if (kind == EvDone) check("ev_frame_cnt", frame_cnt, e.cnt);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    fs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (err != 4'd0) observe(EvErr, err);
        if (done != 4'd0) observe(EvDone, done);
        if (fs_udp_tx && !fs_prev) observe(EvGrant, grant);
      end
      fs_prev = fs_udp_tx;
    end
  end

  // MAC model: finishes each frame after a random duration.
  initial begin
    fd_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (mac_auto && fs_udp_tx) begin
        repeat ($urandom_range(0, 15)) @(negedge clk);
        if (fs_udp_tx) begin
          fd_auto = 1'b1;
          @(negedge clk);
          fd_auto = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_fs"}, fs_udp_tx, 0);
    check({tag, "_len"}, udp_tx_len, 0);
    check({tag, "_sel"}, sel, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_in_time"}, busy, 0);
  endtask

  // Raise mask together; each requester drops on its done/err; lengths scrambled after grant.
  task automatic run_round(input logic [3:0] mask, input int lens[4]);
    int n;
    predict(mask, lens);
    for (int i = 0; i < NREQ; i++) req_len[12*i +: 12] = 12'(lens[i]);
    req = mask;
    n = 0;
    while ((req != 4'd0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NREQ; i++) begin
        if (done[i] || err[i]) req[i] = 1'b0;
        else if (grant[i]) req_len[12*i +: 12] = 12'($urandom);
      end
    end
    check("round_completes", (n < 3000) ? 1 : 0, 1);
  endtask

  function automatic int rand_len();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return int'($urandom_range(LEN_MAX + 1, 4095));
    if (r == 2) return 1;
    if (r == 3) return LEN_MAX;
    return int'($urandom_range(1, LEN_MAX));
  endfunction

  initial begin
    int lens[4];
    rst = 1'b1; req = '0; req_len = '0; fd_force = 1'b0; mac_auto = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single request, MAC done 20 cycles after frame start.
    lens = '{0, 12, 0, 0};
    predict(4'b0010, lens);
    req_len[23:12] = 12'd12;
    req = 4'b0010;
    @(negedge clk);
    check("t1_grant", grant, 4'b0010);
    check("t1_sel", sel, 1);
    check("t1_len", udp_tx_len, 12);
    check("t1_fs", fs_udp_tx, 1);
    repeat (19) @(negedge clk);
    check("t1_fs_held", fs_udp_tx, 1);
    fd_force = 1'b1;
    @(negedge clk);
    fd_force = 1'b0;
    check("t1_fs_drop", fs_udp_tx, 0);
    check("t1_no_early_done", done, 0);
    @(negedge clk);
    check("t1_done", done, 4'b0010);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_grant_clear", grant, 0);
    req = 4'b0000;
    @(negedge clk);
    fd_force = 1'b1;  // stray fd during gap
    @(negedge clk);
    fd_force = 1'b0;
    repeat (5) @(negedge clk);
    check("t1_busy_in_gap", busy, 1);
    @(negedge clk);
    check("t1_busy_low", busy, 0);
    fd_force = 1'b1;  // stray fd while idle
    @(negedge clk);
    fd_force = 1'b0;
    check("t1_idle_fd_busy", busy, 0);
    check("t1_idle_fd_fs", fs_udp_tx, 0);
    check("t1_idle_fd_cnt", frame_cnt, 1);

    // Invalid lengths on requester 3.
    lens = '{0, 0, 0, 0};
    predict(4'b1000, lens);
    req_len[47:36] = 12'd0;
    req = 4'b1000;
    @(negedge clk);
    check("t2_err_zero", err, 4'b1000);
    check("t2_fs_zero", fs_udp_tx, 0);
    req = 4'b0000;
    @(negedge clk);
    check("t2_err_single", err, 0);
    lens = '{0, 0, 0, 1473};
    predict(4'b1000, lens);
    req_len[47:36] = 12'd1473;
    req = 4'b1000;
    @(negedge clk);
    check("t2_err_big", err, 4'b1000);
    check("t2_fs_big", fs_udp_tx, 0);
    req = 4'b0000;
    @(negedge clk);
    check("t2_cnt_kept", frame_cnt, mcnt);

    // All four, then 0 and 2, then random rounds.
    mac_auto = 1'b1;
    for (int i = 0; i < 4; i++) lens[i] = int'($urandom_range(1, LEN_MAX));
    run_round(4'b1111, lens);
    run_round(4'b0101, lens);
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++) lens[i] = rand_len();
      run_round(4'($urandom_range(1, 15)), lens);
    end
    mac_auto = 1'b0;

`ifdef UDP_TX_SCHED_TIMEOUT_EN
    // MAC never answers: abort after 100 UPTX cycles.
    push(EvGrant, 1, 200, 0);
    push(EvErr, 1, 0, 0);
    mptr = 2;
    req_len[23:12] = 12'd200;
    req = 4'b0010;
    @(negedge clk);
    check("to_fs_up", fs_udp_tx, 1);
    repeat (99) @(negedge clk);
    check("to_fs_before", fs_udp_tx, 1);
    check("to_err_before", err, 0);
    @(negedge clk);
    check("to_err", err, 4'b0010);
    check("to_fs_low", fs_udp_tx, 0);
    check("to_grant_low", grant, 0);
    req = 4'b0000;
    wait_idle("to");
    check("to_cnt_kept", frame_cnt, mcnt);
`else
    // MAC never answers: frame start is held indefinitely.
    lens = '{0, 200, 0, 0};
    predict(4'b0010, lens);
    req_len[23:12] = 12'd200;
    req = 4'b0010;
    @(negedge clk);
    check("hang_fs_up", fs_udp_tx, 1);
    repeat (2000) @(negedge clk);
    check("hang_fs_held", fs_udp_tx, 1);
    check("hang_no_err", err, 0);
    fd_force = 1'b1;
    @(negedge clk);
    fd_force = 1'b0;
    @(negedge clk);
    check("hang_done", done, 4'b0010);
    req = 4'b0000;
    wait_idle("hang");
`endif

    // Reset mid-frame after granting requester 0 (pointer moves to 1).
    push(EvGrant, 0, 50, 0);
    req_len[11:0] = 12'd50;
    req = 4'b0001;
    @(negedge clk);
    check("rst_pre_grant", grant, 4'b0001);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    mptr = 0;
    mcnt = 0;
    mac_auto = 1'b1;
    lens = '{100, 0, 300, 0};
    run_round(4'b0101, lens);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
